uop_dispatch_queue: RTL
=======================

Name: uop_dispatch_queue

Overview:
- In-order buffer between the decoder and the functional units.
- Accepts decoded uop_t from decode over valid/ready and stores them in a circular FIFO.
- Issues the head uop to exactly one functional-unit lane selected by its fu field.
- Handles flush, and serializes CSR/fence/system uops against an idle backend.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.
- PERF_W, 32, width of the optional performance counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  discard all buffered uops.
- in_valid_i  in  1  decode offers a uop.
- in_ready_o  out  1  queue can accept; equals count<DEPTH, independent of in_valid_i.
- in_uop_i  in  $bits(uop_t)  decoded uop (decode_pkg::uop_t).
- issue_valid_o  out  7  one-hot lane valid; index = fu_e encoding (0=FU_NONE … 6=FU_CSR).
- issue_ready_i  in  7  per-lane ready from the functional units.
- issue_uop_o  out  $bits(uop_t)  head uop, shared by all lanes.
- backend_idle_i  in  1  no uop in flight past dispatch.
- count_o  out  CNT_W  current occupancy.
- perf_full_stall_o  out  PERF_W  cycles with in_valid_i=1 and in_ready_o=0.
- perf_serial_stall_o  out  PERF_W  cycles the head is blocked by serialization.

Behaviour:
- Interface decision: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset: head=tail=0, count_o=0, state=RUN, issue_valid_o=0, in_ready_o=1, perf counters=0.
- Enqueue fires when in_valid_i & in_ready_o & !flush_i. The uop is written at the tail; tail wraps modulo DEPTH.
- Entry lane rule:
  - Lane is 0 if illegal=1 or fu=FU_NONE; otherwise lane = fu.
  - fu values 7 and above are treated as illegal and go to lane 0.
- Entry serial flag = is_csr | is_fence | is_ecall | is_ebreak | is_mret | illegal.
- issue_uop_o is driven combinationally from the head entry and is X-free (zero) when empty.
- Issue fires when head is valid & issue_valid_o[lane] & issue_ready_i[lane]. Head advances, with wrap.
- Latency: a uop enqueued in cycle N is visible at issue in cycle N+1. There is no bypass.
- Simultaneous enqueue and issue: count is unchanged. Enqueue is legal when full only if it is not full; there is no full-with-pop bypass.
- State machine:
  - RUN:
    - Non-serial head: assert its lane valid.
    - Serial head and backend_idle_i=0: go to DRAIN, no valid.
    - Serial head and backend_idle_i=1: assert lane valid. On issue go to SERIAL_WAIT.
  - DRAIN: no valid. When backend_idle_i=1, return to RUN; the head issues from RUN next cycle.
  - SERIAL_WAIT: no valid for any uop. When backend_idle_i=1, go to RUN.
- Flush:
  - flush_i=1 forces issue_valid_o=0 in that cycle and blocks enqueue and issue.
  - Next cycle: head=tail=0, count=0, state=RUN.
  - Flush has priority over every other event.
- Reset mid-operation behaves identically to flush and also clears the perf counters.
- issue_valid_o is never multi-hot. Holding a uop at issue does not change it while its lane is not ready (stable valid/data).
- perf_serial_stall_o increments in any cycle where count>0 and state is DRAIN or SERIAL_WAIT, or a serial head is blocked by !backend_idle_i.

Optional Feature:
- Macro: UOP_DISPATCH_PERF_EN.
- Defined: both perf counters are implemented. They saturate at all-ones and are cleared only by reset, not by flush.
- Undefined: the counter registers are absent and both perf outputs are tied to 0.

Test Plan:
- Fill and drain with DEPTH=8, all issue_ready_i=0:
  - Push 9 ALU uops.
  - Required: in_ready_o=0 after the 8th, count_o=8, perf_full_stall_o=1 for the single blocked cycle.
  - Then issue_ready_i[1]=1 drains in 8 cycles in order (pc 0x1000,0x1004,…).
- Lane routing: enqueue BRANCH, LSU, MUL, DIV, CSR, plus one illegal ALU uop.
  - Required: issue_valid_o = 7'b0000100, 0001000, 0010000, 0100000, 1000000, 0000001 respectively.
- Serialization: backend_idle_i=0 with CSR at head followed by an ALU uop.
  - Required: no issue_valid_o while idle=0.
  - Idle rises at cycle T: CSR issues at T+1, then SERIAL_WAIT. The ALU uop issues only after backend_idle_i=1 again.
- Flush mid-stream: 5 entries buffered, flush_i=1 together with in_valid_i=1.
  - Required: issue_valid_o=0 that cycle, count_o=0 next cycle, the concurrent uop is not stored.
- Wrap-around: 20 enqueue/issue pairs with one-cycle ready.
  - Required: in-order pc sequence preserved across pointer wrap, count_o never exceeds 2.
- Reset mid-DRAIN: rst_i=1 for one cycle.
  - Required: state RUN, count_o=0, all outputs at reset values.
  - With UOP_DISPATCH_PERF_EN defined, counters read 0.

Source files
------------

// File: rtl/uop_dispatch_queue.sv
// In-order dispatch queue between decode and the functional-unit lanes, with flush and CSR/fence serialization.
// Optional perf counters are built when UOP_DISPATCH_PERF_EN is defined; otherwise the perf outputs read zero.

package decode_pkg;

  typedef enum logic [2:0] {
    FU_NONE   = 3'd0,
    FU_ALU    = 3'd1,
    FU_BRANCH = 3'd2,
    FU_LSU    = 3'd3,
    FU_MUL    = 3'd4,
    FU_DIV    = 3'd5,
    FU_CSR    = 3'd6
  } fu_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    fu_e         fu;
    logic        is_csr;
    logic        is_fence;
    logic        is_ecall;
    logic        is_ebreak;
    logic        is_mret;
    logic        illegal;
  } uop_t;

endpackage

module uop_dispatch_queue
  import decode_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1),
  parameter int PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  uop_t              in_uop_i,
  output logic [6:0]        issue_valid_o,
  input  logic [6:0]        issue_ready_i,
  output uop_t              issue_uop_o,
  input  logic              backend_idle_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [PERF_W-1:0] perf_full_stall_o,
  output logic [PERF_W-1:0] perf_serial_stall_o
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               NLANE   = 7;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Lane and serial flag are resolved once at enqueue so the issue path stays shallow.
  typedef struct packed {
    uop_t       uop;
    logic [2:0] lane;
    logic       serial;
  } entry_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_SERIAL_WAIT
  } state_e;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_e           state_q, state_d;

  entry_t           in_entry;
  entry_t           head_entry;
  logic [2:0]       fu_raw;
  logic             empty;
  logic             enq;
  logic             iss;
  logic             head_go;
  logic [NLANE-1:0] issue_valid;

  always_comb begin
    fu_raw          = in_uop_i.fu;
    in_entry.uop    = in_uop_i;
    in_entry.serial = in_uop_i.is_csr | in_uop_i.is_fence | in_uop_i.is_ecall |
                      in_uop_i.is_ebreak | in_uop_i.is_mret | in_uop_i.illegal;
    // Encoding 7 has no lane; it is handled like an illegal uop.
    if (in_uop_i.illegal || fu_raw == 3'd0 || fu_raw == 3'd7) begin
      in_entry.lane = 3'd0;
    end else begin
      in_entry.lane = fu_raw;
    end
  end

  always_comb begin
    empty      = (count_q == '0);
    in_ready_o = (count_q < DEPTH_C);
    head_entry = mem_q[head_q];
    enq        = in_valid_i && in_ready_o && !flush_i;
    head_go    = !flush_i && !empty && (state_q == ST_RUN) &&
                 (!head_entry.serial || backend_idle_i);
    issue_valid = '0;
    if (head_go) begin
      issue_valid = NLANE'(1) << head_entry.lane;
    end
    iss = head_go && issue_ready_i[head_entry.lane];
  end

  assign issue_valid_o = issue_valid;
  assign issue_uop_o   = empty ? '0 : head_entry.uop;
  assign count_o       = count_q;

  always_comb begin
    mem_d = mem_q;
    if (enq) begin
      mem_d[tail_q] = in_entry;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (iss) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({enq, iss})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!empty && head_entry.serial) begin
            if (!backend_idle_i) begin
              state_d = ST_DRAIN;
            end else if (iss) begin
              state_d = ST_SERIAL_WAIT;
            end
          end
        end
        ST_DRAIN: begin
          if (backend_idle_i) begin
            state_d = ST_RUN;
          end
        end
        ST_SERIAL_WAIT: begin
          if (backend_idle_i) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= ST_RUN;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

`ifdef UOP_DISPATCH_PERF_EN
  logic [PERF_W-1:0] perf_full_q, perf_full_d;
  logic [PERF_W-1:0] perf_serial_q, perf_serial_d;
  logic              full_stall;
  logic              serial_stall;

  always_comb begin
    full_stall    = in_valid_i && !in_ready_o;
    serial_stall  = !empty && ((state_q != ST_RUN) ||
                               (head_entry.serial && !backend_idle_i));
    perf_full_d   = perf_full_q;
    perf_serial_d = perf_serial_q;
    if (full_stall && (perf_full_q != '1)) begin
      perf_full_d = perf_full_q + PERF_W'(1);
    end
    if (serial_stall && (perf_serial_q != '1)) begin
      perf_serial_d = perf_serial_q + PERF_W'(1);
    end
  end

  // Flush deliberately leaves these alone; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_full_q   <= '0;
      perf_serial_q <= '0;
    end else begin
      perf_full_q   <= perf_full_d;
      perf_serial_q <= perf_serial_d;
    end
  end

  assign perf_full_stall_o   = perf_full_q;
  assign perf_serial_stall_o = perf_serial_q;
`else
  assign perf_full_stall_o   = '0;
  assign perf_serial_stall_o = '0;
`endif

endmodule
